// File: rtl/ex_stage.sv
// ex_stage: execute stage of the pipeline.
// Computes the ALU result, the branch decision and target, and the destination
// register, then registers them with the pass-through controls into EX/MEM.
// Optional iterative shift-add multiplier, built only when EX_MULT_EN is defined;
// without it MULT behaves like any unknown opcode and stall stays 0.
//
// Flow control: stall is the only handshake with upstream. While stall=1 the
// ID/EX fields must be held stable. The instruction on the inputs is consumed
// at a posedge where stall=0.
module ex_stage #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [5:0]  alu_op,
    input  logic        reg_dst,
    input  logic        alu_src,
    input  logic        branch,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    input  logic [6:0]  pc_next,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [31:0] sign_extend,
    input  logic [4:0]  reg1,
    input  logic [4:0]  reg2,
    output logic        stall,
    output logic [31:0] alu_result_mem,
    output logic [31:0] write_data_mem,
    output logic [4:0]  dest_reg_mem,
    output logic [6:0]  branch_target_mem,
    output logic        branch_taken_mem,
    output logic        mem_write_mem,
    output logic        mem_read_mem,
    output logic        reg_write_mem,
    output logic        mem_to_reg_mem
);

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SLT = 6'h2A;
    localparam logic [5:0] OP_SLL = 6'h00;
    localparam logic [5:0] OP_SRL = 6'h02;

    // reg1 is carried in the ID/EX record for the forwarding unit only
    logic unused_ok;
    assign unused_ok = ^reg1;

    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] alu_out;
    logic [4:0]  dest;
    logic [6:0]  target;
    logic        taken;
    logic [31:0] result_sel;
    logic        bubble;

    assign op_b   = alu_src ? sign_extend : data2;
    assign shamt  = sign_extend[10:6];
    assign dest   = reg_dst ? sign_extend[15:11] : reg2;
    assign target = pc_next + sign_extend[6:0];
    // Branch compare always uses the register values, never the immediate
    assign taken  = branch & (data1 == data2);

    // Single-cycle ALU; unknown opcodes (and MULT) give 0
    always_comb begin
        alu_out = '0;
        case (alu_op)
            OP_ADD:  alu_out = data1 + op_b;
            OP_SUB:  alu_out = data1 - op_b;
            OP_AND:  alu_out = data1 & op_b;
            OP_OR:   alu_out = data1 | op_b;
            OP_XOR:  alu_out = data1 ^ op_b;
            OP_NOR:  alu_out = ~(data1 | op_b);
            OP_SLT:  alu_out = {31'd0, $signed(data1) < $signed(op_b)};
            OP_SLL:  alu_out = op_b << shamt;
            OP_SRL:  alu_out = op_b >> shamt;
            default: alu_out = '0;
        endcase
    end

`ifdef EX_MULT_EN
    localparam logic [5:0] OP_MULT = 6'h18;
    localparam int         CW      = $clog2(MUL_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    logic [CW-1:0] count;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] product;

    // Multiplier FSM: latch operands, 32 shift-add steps, one cycle to hand off
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            count   <= '0;
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (alu_op == OP_MULT) begin
                        mcand   <= data1;
                        mplier  <= op_b;
                        count   <= '0;
                        product <= '0;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // mcand is pre-shifted, so mplier[0] is the current bit
                    if (mplier[0]) begin
                        product <= product + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == CW'(MUL_CYCLES - 1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign stall      = !rst && !flush &&
                        (((state == S_IDLE) && (alu_op == OP_MULT)) || (state == S_BUSY));
    assign bubble     = flush || ((state == S_IDLE) && (alu_op == OP_MULT)) || (state == S_BUSY);
    assign result_sel = (state == S_DONE) ? product : alu_out;
`else
    logic [31:0] unused_cfg;
    assign unused_cfg = 32'(MUL_CYCLES);

    assign stall      = 1'b0;
    assign bubble     = flush;
    assign result_sel = alu_out;
`endif

    // EX/MEM pipeline register; a bubble clears every control bit
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_mem    <= '0;
            write_data_mem    <= '0;
            dest_reg_mem      <= '0;
            branch_target_mem <= '0;
            branch_taken_mem  <= 1'b0;
            mem_write_mem     <= 1'b0;
            mem_read_mem      <= 1'b0;
            reg_write_mem     <= 1'b0;
            mem_to_reg_mem    <= 1'b0;
        end else begin
            alu_result_mem    <= result_sel;
            write_data_mem    <= data2;
            dest_reg_mem      <= dest;
            branch_target_mem <= target;
            if (bubble) begin
                branch_taken_mem <= 1'b0;
                mem_write_mem    <= 1'b0;
                mem_read_mem     <= 1'b0;
                reg_write_mem    <= 1'b0;
                mem_to_reg_mem   <= 1'b0;
            end else begin
                branch_taken_mem <= taken;
                mem_write_mem    <= mem_write;
                mem_read_mem     <= mem_read;
                reg_write_mem    <= reg_write;
                mem_to_reg_mem   <= mem_to_reg;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed bench for ex_stage.
// Table of single-cycle vectors plus hand-written multi-cycle sequences
// (reset, flush, and the multiplier when EX_MULT_EN is defined).
module tb_ex_stage;

    localparam logic [5:0] OP_ADD  = 6'h20;
    localparam logic [5:0] OP_SUB  = 6'h22;
    localparam logic [5:0] OP_AND  = 6'h24;
    localparam logic [5:0] OP_OR   = 6'h25;
    localparam logic [5:0] OP_XOR  = 6'h26;
    localparam logic [5:0] OP_NOR  = 6'h27;
    localparam logic [5:0] OP_SLT  = 6'h2A;
    localparam logic [5:0] OP_SLL  = 6'h00;
    localparam logic [5:0] OP_SRL  = 6'h02;
    localparam logic [5:0] OP_MULT = 6'h18;
    localparam logic [5:0] OP_NONE = 6'h3F;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, reg_dst, alu_src, branch;
    logic        mem_write, mem_read, reg_write, mem_to_reg;
    logic [5:0]  alu_op;
    logic [6:0]  pc_next;
    logic [31:0] data1, data2, sign_extend;
    logic [4:0]  reg1, reg2;
    logic        stall;
    logic [31:0] alu_result_mem, write_data_mem;
    logic [4:0]  dest_reg_mem;
    logic [6:0]  branch_target_mem;
    logic        branch_taken_mem, mem_write_mem, mem_read_mem, reg_write_mem, mem_to_reg_mem;

    ex_stage #(.MUL_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .alu_op(alu_op),
        .reg_dst(reg_dst), .alu_src(alu_src), .branch(branch),
        .mem_write(mem_write), .mem_read(mem_read), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .pc_next(pc_next), .data1(data1), .data2(data2),
        .sign_extend(sign_extend), .reg1(reg1), .reg2(reg2), .stall(stall),
        .alu_result_mem(alu_result_mem), .write_data_mem(write_data_mem),
        .dest_reg_mem(dest_reg_mem), .branch_target_mem(branch_target_mem),
        .branch_taken_mem(branch_taken_mem), .mem_write_mem(mem_write_mem),
        .mem_read_mem(mem_read_mem), .reg_write_mem(reg_write_mem),
        .mem_to_reg_mem(mem_to_reg_mem)
    );

    // ---------------- scoreboard ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ctrl = {mem_write, mem_read, reg_write, mem_to_reg}
    typedef struct {
        logic [5:0]  op;
        logic        src;
        logic        rdst;
        logic        br;
        logic [3:0]  ctrl;
        logic [6:0]  pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] se;
        logic [4:0]  r2;
        logic [31:0] e_res;
        logic [4:0]  e_dest;
        logic [6:0]  e_tgt;
        logic        e_taken;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mkv(
        input logic [5:0] op, input logic src, input logic rdst, input logic br,
        input logic [3:0] ctrl, input logic [6:0] pc, input logic [31:0] d1,
        input logic [31:0] d2, input logic [31:0] se, input logic [4:0] r2,
        input logic [31:0] e_res, input logic [4:0] e_dest, input logic [6:0] e_tgt,
        input logic e_taken);
        vec_t v;
        v.op = op; v.src = src; v.rdst = rdst; v.br = br; v.ctrl = ctrl; v.pc = pc;
        v.d1 = d1; v.d2 = d2; v.se = se; v.r2 = r2;
        v.e_res = e_res; v.e_dest = e_dest; v.e_tgt = e_tgt; v.e_taken = e_taken;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input vec_t v);
        alu_op = v.op; alu_src = v.src; reg_dst = v.rdst; branch = v.br;
        {mem_write, mem_read, reg_write, mem_to_reg} = v.ctrl;
        pc_next = v.pc; data1 = v.d1; data2 = v.d2; sign_extend = v.se;
        reg2 = v.r2; reg1 = 5'd0;
    endtask

    task automatic drive_nop();
        drive(mkv(OP_NONE, 1'b0, 1'b0, 1'b0, 4'b0000, 7'd0, 32'd0, 32'd0, 32'd0, 5'd0,
                  32'd0, 5'd0, 7'd0, 1'b0));
    endtask

    // ADD with reg_write; checks stall low and result one edge later
    task automatic add_check(input string name, input logic [31:0] a, input logic [31:0] b);
        drive(mkv(OP_ADD, 1'b0, 1'b0, 1'b0, 4'b0010, 7'd0, a, b, 32'd0, 5'd1,
                  32'd0, 5'd0, 7'd0, 1'b0));
        @(negedge clk);
        chk({name, "_stall"}, 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk({name, "_result"}, alu_result_mem, a + b);
        chk({name, "_rw"}, 32'(reg_write_mem), 32'd1);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            alu_op      = 6'($urandom_range(0, 63));
            alu_src     = 1'($urandom_range(0, 1));
            reg_dst     = 1'($urandom_range(0, 1));
            branch      = 1'($urandom_range(0, 1));
            {mem_write, mem_read, reg_write, mem_to_reg} = 4'($urandom_range(0, 15));
            pc_next     = 7'($urandom_range(0, 127));
            data1       = $urandom;
            data2       = $urandom;
            sign_extend = $urandom;
            reg1        = 5'($urandom_range(0, 31));
            reg2        = 5'($urandom_range(0, 31));
            flush       = 1'($urandom_range(0, 1));
            if (c == 1) begin
                alu_op = OP_MULT;
                flush  = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk({name, "_result"}, alu_result_mem, 32'd0);
        chk({name, "_wdata"}, write_data_mem, 32'd0);
        chk({name, "_dest"}, 32'(dest_reg_mem), 32'd0);
        chk({name, "_target"}, 32'(branch_target_mem), 32'd0);
        chk({name, "_taken"}, 32'(branch_taken_mem), 32'd0);
        chk({name, "_ctrl"}, 32'({mem_write_mem, mem_read_mem, reg_write_mem, mem_to_reg_mem}), 32'd0);
        chk({name, "_stall"}, 32'(stall), 32'd0);
        rst   = 1'b0;
        flush = 1'b0;
        drive_nop();
    endtask

`ifdef EX_MULT_EN
    // Presents MULT a*b (reg_write=1, dest reg2=5) and follows it to completion
    task automatic mult_run(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input bit flush_at_done);
        int  n;
        int  bad;
        bit  done;
        drive(mkv(OP_MULT, 1'b0, 1'b0, 1'b0, 4'b0010, 7'd0, a, b, 32'd0, 5'd5,
                  32'd0, 5'd0, 7'd0, 1'b0));
        n = 0; bad = 0; done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (stall) begin
                n++;
                @(posedge clk); #1;
                if (reg_write_mem !== 1'b0) bad++;
            end else begin
                done = 1'b1;
                if (flush_at_done) flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
            end
        end
        chk("mult_stall_cycles", 32'(n), 32'd33);
        chk("mult_bubbles", 32'(bad), 32'd0);
        if (flush_at_done) begin
            chk("done_flush_rw", 32'(reg_write_mem), 32'd0);
        end else begin
            chk("mult_result", alu_result_mem, exp);
            chk("mult_rw", 32'(reg_write_mem), 32'd1);
            chk("mult_dest", 32'(dest_reg_mem), 32'd5);
        end
    endtask
`endif

    // ---------------- test ----------------
    initial begin
        rst = 1'b1; flush = 1'b0;
        drive_nop();

        vecs[0]  = mkv(OP_ADD, 0, 1, 0, 4'b0010, 7'd10,  32'h7FFFFFFF, 32'h1, 32'h0000_4800, 5'd0,
                       32'h80000000, 5'd9, 7'd10, 0);
        vecs[1]  = mkv(OP_SUB, 0, 0, 0, 4'b0010, 7'd20,  32'h0, 32'h1, 32'h0, 5'd4,
                       32'hFFFFFFFF, 5'd4, 7'd20, 0);
        vecs[2]  = mkv(OP_SLT, 0, 0, 0, 4'b0010, 7'd0,   32'hFFFFFFFF, 32'h1, 32'h0, 5'd7,
                       32'h1, 5'd7, 7'd0, 0);
        vecs[3]  = mkv(OP_SRL, 0, 0, 0, 4'b0010, 7'd1,   32'h0, 32'hF0000000, 32'h0000_0100, 5'd3,
                       32'h0F000000, 5'd3, 7'd1, 0);
        vecs[4]  = mkv(OP_SLL, 0, 1, 0, 4'b0010, 7'h50,  32'h0, 32'h1, 32'h0000_07C0, 5'd2,
                       32'h80000000, 5'd0, 7'h10, 0);
        vecs[5]  = mkv(OP_AND, 0, 0, 0, 4'b0001, 7'd0,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 5'd1,
                       32'hF000F000, 5'd1, 7'd0, 0);
        vecs[6]  = mkv(OP_OR,  0, 0, 0, 4'b0001, 7'd0,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 5'd1,
                       32'hFFF0FFF0, 5'd1, 7'd0, 0);
        vecs[7]  = mkv(OP_XOR, 0, 0, 0, 4'b0001, 7'd0,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 5'd1,
                       32'h0FF00FF0, 5'd1, 7'd0, 0);
        vecs[8]  = mkv(OP_NOR, 0, 0, 0, 4'b0001, 7'd0,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 5'd1,
                       32'h000F000F, 5'd1, 7'd0, 0);
        vecs[9]  = mkv(OP_ADD, 1, 1, 0, 4'b1000, 7'd3,   32'd5, 32'd99, 32'hFFFFFFFE, 5'd0,
                       32'd3, 5'd31, 7'd1, 0);
        vecs[10] = mkv(OP_SUB, 0, 0, 1, 4'b0000, 7'h7E,  32'd5, 32'd5, 32'd3, 5'd2,
                       32'd0, 5'd2, 7'h01, 1);
        vecs[11] = mkv(OP_SUB, 0, 0, 1, 4'b0000, 7'h7E,  32'd5, 32'd6, 32'd3, 5'd2,
                       32'hFFFFFFFF, 5'd2, 7'h01, 0);
        vecs[12] = mkv(OP_ADD, 1, 0, 1, 4'b0000, 7'd0,   32'd8, 32'd8, 32'd0, 5'd6,
                       32'd8, 5'd6, 7'd0, 1);
        vecs[13] = mkv(OP_NONE, 0, 0, 0, 4'b1111, 7'd5,  32'd1, 32'd2, 32'd0, 5'd9,
                       32'd0, 5'd9, 7'd5, 0);
        vecs[14] = mkv(OP_SLT, 0, 0, 0, 4'b0010, 7'd0,   32'd1, 32'hFFFFFFFF, 32'h0, 5'd8,
                       32'd0, 5'd8, 7'd0, 0);
        vecs[15] = mkv(OP_SUB, 0, 0, 0, 4'b0010, 7'd0,   32'h80000000, 32'h1, 32'h0, 5'd8,
                       32'h7FFFFFFF, 5'd8, 7'd0, 0);

        do_reset("reset");

        // Single-cycle table: each result must appear after exactly one posedge
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_result", i), alu_result_mem, vecs[i].e_res);
            chk($sformatf("v%0d_wdata", i), write_data_mem, vecs[i].d2);
            chk($sformatf("v%0d_dest", i), 32'(dest_reg_mem), 32'(vecs[i].e_dest));
            chk($sformatf("v%0d_target", i), 32'(branch_target_mem), 32'(vecs[i].e_tgt));
            chk($sformatf("v%0d_taken", i), 32'(branch_taken_mem), 32'(vecs[i].e_taken));
            chk($sformatf("v%0d_ctrl", i),
                32'({mem_write_mem, mem_read_mem, reg_write_mem, mem_to_reg_mem}),
                32'(vecs[i].ctrl));
        end

        // Flush on an ordinary op: every control squashed
        drive(mkv(OP_ADD, 0, 0, 1, 4'b1111, 7'd0, 32'd3, 32'd3, 32'd0, 5'd1,
                  32'd0, 5'd0, 7'd0, 0));
        flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("flush_ctrl", 32'({mem_write_mem, mem_read_mem, reg_write_mem, mem_to_reg_mem}), 32'd0);
        chk("flush_taken", 32'(branch_taken_mem), 32'd0);
        flush = 1'b0;

`ifdef EX_MULT_EN
        mult_run(32'h12345, 32'h10, 32'h123450, 1'b0);
        // back-to-back: second MULT enters the cycle after DONE
        mult_run(32'd7, 32'd3, 32'd21, 1'b0);
        mult_run(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0);
        add_check("after_mult", 32'd10, 32'd20);

        // Abort at BUSY cycle 10
        drive(mkv(OP_MULT, 0, 0, 0, 4'b0010, 7'd0, 32'd7, 32'd3, 32'd0, 5'd5,
                  32'd0, 5'd0, 7'd0, 0));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("abort_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("abort_rw", 32'(reg_write_mem), 32'd0);
        flush = 1'b0;
        add_check("post_abort", 32'd2, 32'd3);
        mult_run(32'd7, 32'd3, 32'd21, 1'b0);

        // Flush in the DONE cycle discards the product
        mult_run(32'd5, 32'd5, 32'd25, 1'b1);
        add_check("post_done_flush", 32'd4, 32'd4);

        // Reset at BUSY cycle 5
        drive(mkv(OP_MULT, 0, 0, 0, 4'b0010, 7'd0, 32'd9, 32'd9, 32'd0, 5'd5,
                  32'd0, 5'd0, 7'd0, 0));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
        end
        do_reset("busy_reset");
        add_check("post_reset", 32'd6, 32'd7);
`else
        // Without the multiplier MULT is an unknown op: result 0, latency 1
        drive(mkv(OP_MULT, 0, 0, 0, 4'b0010, 7'd0, 32'h12345, 32'h10, 32'd0, 5'd5,
                  32'd0, 5'd0, 7'd0, 0));
        @(negedge clk);
        chk("mult_off_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("mult_off_result", alu_result_mem, 32'd0);
        chk("mult_off_rw", 32'(reg_write_mem), 32'd1);
        chk("mult_off_dest", 32'(dest_reg_mem), 32'd5);
        add_check("post_mult_off", 32'd6, 32'd7);
        do_reset("late_reset");
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
